// File: rtl/pixel_expander_if.sv
// Capture/expansion bus of pixel_expander: memory A read side, start/status
// handshake and the valid/ready byte stream toward memory B.
interface pixel_expander_if #(
  parameter int N_PIX = 64,
  parameter int DW    = 8
);
  localparam int AW  = $clog2(N_PIX);
  localparam int OAW = $clog2(3*N_PIX);

  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic           data_rdy;
  logic           busy;
  logic           data_done;
  logic           frame_err;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [OAW-1:0] out_addr;

  modport master (
    output rd_en, rd_addr, rd_data, data_rdy, out_ready,
    input  busy, data_done, frame_err, out_valid, out_data, out_addr
  );

  modport slave (
    input  rd_en, rd_addr, rd_data, data_rdy, out_ready,
    output busy, data_done, frame_err, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/pixel_expander.sv
// Buffers a frame of RGB332 pixels read from memory A and streams it back out
// as RGB888 component bytes (R,G,B per pixel) toward memory B.
module pixel_expander #(
  parameter int N_PIX = 64,
  parameter int DW    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pixel_expander_if.slave  bus
);
  localparam int AW  = $clog2(N_PIX);
  localparam int OAW = $clog2(3*N_PIX);
  localparam int CW  = $clog2(N_PIX+1);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_buf [N_PIX];
  logic            r_rd_en_d;
  logic [AW-1:0]   r_rd_addr_d;
  logic [CW-1:0]   r_cap_cnt;
  logic [AW-1:0]   r_pix;
  logic [1:0]      r_comp;
  logic            r_busy, r_done, r_err, r_valid;
  logic [DW-1:0]   r_data;
  logic [OAW-1:0]  r_addr;

  logic            w_cap_we, w_xfer, w_last;
  logic [AW-1:0]   w_npix;
  logic [1:0]      w_ncomp;

  // Bit replication widens each 3/3/2-bit field to a full-scale byte.
  function automatic logic [DW-1:0] expand(input logic [DW-1:0] p, input logic [1:0] c);
    case (c)
      2'd0:    expand = {p[7:5], p[7:5], p[7:6]};
      2'd1:    expand = {p[4:2], p[4:2], p[4:3]};
      default: expand = {p[1:0], p[1:0], p[1:0], p[1:0]};
    endcase
  endfunction

  // A return landing on the start cycle is dropped so frame_err matches the buffer.
  assign w_cap_we = r_rd_en_d && (r_state == S_IDLE) && !bus.data_rdy;
  assign w_xfer   = r_valid && bus.out_ready;
  assign w_last   = (r_addr == OAW'(3*N_PIX-1));
  assign w_ncomp  = (r_comp == 2'd2) ? 2'd0 : r_comp + 2'd1;
  assign w_npix   = (r_comp == 2'd2) ? r_pix + 1'b1 : r_pix;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_en_d   <= 1'b0;
      r_rd_addr_d <= '0;
      for (int i = 0; i < N_PIX; i++) r_buf[i] <= '0;
    end else begin
      r_rd_en_d   <= bus.rd_en;
      r_rd_addr_d <= bus.rd_addr;
      if (w_cap_we) r_buf[r_rd_addr_d] <= bus.rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_cap_cnt <= '0;
      r_pix     <= '0;
      r_comp    <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cap_we && r_cap_cnt != CW'(N_PIX)) r_cap_cnt <= r_cap_cnt + 1'b1;
          if (bus.data_rdy) begin
            r_state <= S_EXPAND;
            r_err   <= (r_cap_cnt != CW'(N_PIX));
            r_pix   <= '0;
            r_comp  <= 2'd0;
            r_addr  <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_data  <= expand(r_buf[0], 2'd0);
          end
        end
        S_EXPAND: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_addr  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_comp  <= w_ncomp;
              r_pix   <= w_npix;
              r_data  <= expand(r_buf[w_npix], w_ncomp);
            end
          end
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_cap_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.data_done = r_done;
  assign bus.frame_err = r_err;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_addr  = r_addr;
endmodule

// File: tb/tb_pixel_expander.sv
// Randomized bench for pixel_expander against an arithmetic RGB332->RGB888 model.
module tb_pixel_expander;
  localparam int N_PIX = 64;
  localparam int NB    = 3*N_PIX;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pixel_expander_if #(.N_PIX(N_PIX), .DW(8)) bus();
  pixel_expander #(.N_PIX(N_PIX), .DW(8)) dut (.i_clk(clk), .i_reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model_buf [N_PIX];
  logic [7:0] got [NB];

  function automatic logic [7:0] ref_byte(input int a);
    int p, c, r, g, b, v;
    p = int'(model_buf[a/3]);
    c = a % 3;
    r = (p >> 5) & 7;
    g = (p >> 2) & 7;
    b = p & 3;
    case (c)
      0:       v = r*32 + r*4 + r/2;
      1:       v = g*32 + g*4 + g/2;
      default: v = b*85;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [7:0] pat(input int i);
    case (i)
      0:       return 8'hFF;
      1:       return 8'h00;
      2:       return 8'hE0;
      3:       return 8'h49;
      default: return 8'(i);
    endcase
  endfunction

  task automatic drive_idle();
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_data = '0;
    bus.data_rdy = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_PIX; i++) model_buf[i] = 8'h00;
  endtask

  // n pipelined reads: strobe at one negedge, data on the next
  task automatic capture(input int n, input bit use_pat);
    logic [7:0] pend;
    pend = 8'h00;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_between_frames: busy=%b valid=%b, want 0 0", bus.busy, bus.out_valid);
        end
      end
      if (i > 0) begin
        bus.rd_data = pend;
        model_buf[i-1] = pend;
      end
      bus.rd_en = (i < n);
      bus.rd_addr = 6'(i % N_PIX);
      if (i < n) pend = use_pat ? pat(i) : 8'($urandom);
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic run_frame(input bit rand_ready, input bit exp_err, input bit strobe, input int abort_at);
    int exp_addr;
    bit prev_stall, finished;
    logic [7:0] pd, pa;
    exp_addr = 0; prev_stall = 0; finished = 0; pd = 0; pa = 0;
    @(negedge clk);
    bus.data_rdy = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.data_rdy = 1'b0;
      if (exp_addr == NB) begin
        n_tests++;
        if (bus.data_done !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_addr !== 8'd0 || bus.out_data !== 8'd0) begin
          n_fail++;
          $display("FAIL done_cycle: done=%b busy=%b valid=%b addr=%0d data=%h, want 1 1 0 0 00",
                   bus.data_done, bus.busy, bus.out_valid, bus.out_addr, bus.out_data);
        end
        if (!rand_ready) begin
          n_tests++;
          if (cyc != NB) begin
            n_fail++;
            $display("FAIL throughput: done after %0d cycles, want %0d", cyc, NB);
          end
        end
        finished = 1;
        break;
      end
      if (cyc == 0) begin
        n_tests++;
        if (bus.frame_err !== exp_err || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL start: frame_err=%b busy=%b, want %b 1", bus.frame_err, bus.busy, exp_err);
        end
      end
      n_tests++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL out_valid: got %b at byte %0d, want 1", bus.out_valid, exp_addr);
      end
      if (prev_stall) begin
        n_tests++;
        if (bus.out_data !== pd || bus.out_addr !== pa) begin
          n_fail++;
          $display("FAIL stall_hold: data=%h addr=%0d, want %h %0d", bus.out_data, bus.out_addr, pd, pa);
        end
      end
      n_tests++;
      if (bus.out_addr !== 8'(exp_addr) || bus.out_data !== ref_byte(exp_addr)) begin
        n_fail++;
        $display("FAIL byte: addr=%0d data=%h, want %0d %h", bus.out_addr, bus.out_data, exp_addr, ref_byte(exp_addr));
      end
      got[exp_addr] = bus.out_data;
      if (exp_addr == abort_at) begin
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_addr !== 8'd0 ||
            bus.out_data !== 8'd0 || bus.data_done !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset: valid=%b busy=%b addr=%0d data=%h done=%b, want all 0",
                   bus.out_valid, bus.busy, bus.out_addr, bus.out_data, bus.data_done);
        end
        bus.out_ready = 1'b0;
        bus.rd_en = 1'b0;
        return;
      end
      if (strobe && exp_addr < 150) begin
        bus.rd_en = 1'($urandom);
        bus.rd_addr = 6'($urandom);
        bus.rd_data = 8'($urandom);
      end else begin
        bus.rd_en = 1'b0;
      end
      bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
      pd = bus.out_data;
      pa = bus.out_addr;
      prev_stall = !bus.out_ready;
      if (bus.out_valid === 1'b1 && bus.out_ready) exp_addr++;
    end
    if (!finished) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: stuck at byte %0d", exp_addr);
      return;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.data_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_end: done=%b busy=%b, want 0 0", bus.data_done, bus.busy);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    clear_model();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.data_done !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b err=%b valid=%b data=%h addr=%0d, want all 0",
               bus.busy, bus.data_done, bus.frame_err, bus.out_valid, bus.out_data, bus.out_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b valid=%b, want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_short_frame();
    capture(10, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_full_frame();
    logic [7:0] exp12 [12];
    exp12 = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h49, 8'h49, 8'h55};
    capture(N_PIX, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (got[i] !== exp12[i]) begin
        n_fail++;
        $display("FAIL known_bytes: addr %0d got %h, want %h", i, got[i], exp12[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    capture(N_PIX, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, -1);
  endtask

  // Strobes during EXPAND must not disturb the buffer or the capture count.
  task automatic test_capture_while_busy();
    capture(N_PIX, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, -1);
    run_frame(1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    capture(N_PIX, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, -1);
    capture(N_PIX, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    capture(N_PIX, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 100);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    run_frame(1'b0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_full_frame();
    test_backpressure();
    test_capture_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
